// File: rtl/mulu_x2y2_seq.sv
`default_nettype none
// ============================================================================
// Module      : mulu_x2y2_seq
// Description : Sequential WIDTH x WIDTH unsigned multiplier that drives an
//               external combinational 2x2 multiplier one digit pair per
//               clock and shift-accumulates the 4-bit partial products into a
//               2*WIDTH result.
//               Optional macro MULU_SEQ_SIGNED_EN adds an 'sgn' input that
//               selects two's-complement operands (sign-magnitude internally).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid/ready  - operand handshake (a, b [, sgn])
//               mx, my          - digit pair to the 2x2 multiplier x/y
//               mp              - 4-bit product returned by the 2x2 multiplier
//               out_valid/ready - result handshake (result)
// Revision    : 1.0 - initial release
// ============================================================================
module mulu_x2y2_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef MULU_SEQ_SIGNED_EN
    input  logic                 sgn,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [1:0]           mx,
    output logic [1:0]           my,
    input  logic [3:0]           mp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int C_DIGITS = WIDTH / 2;
    localparam int C_CW     = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [WIDTH-1:0]     r_ra;
    logic [WIDTH-1:0]     r_rb;
    logic [2*WIDTH-1:0]   r_acc;
    logic [C_CW-1:0]      r_i;
    logic [C_CW-1:0]      r_j;

    logic                 w_accept;
    logic                 w_last;
    logic [C_CW+1:0]      w_shamt;
    logic [2*WIDTH-1:0]   w_mp_ext;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_i == C_LAST) && (r_j == C_LAST);

    // Digit pair (i, j) carries weight 4^(i+j), i.e. a shift of 2*(i+j).
    assign w_shamt  = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
    assign w_mp_ext = (2*WIDTH)'(mp);
    assign w_sum    = r_acc + (w_mp_ext << w_shamt);

`ifdef MULU_SEQ_SIGNED_EN
    logic r_neg;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps
    // onto 2^(WIDTH-1) without overflow.
    assign w_a_mag = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign w_b_mag = (sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    // Sign is folded into the last accumulate so DONE is reached on time.
    assign w_final = r_neg ? ((2*WIDTH)'(0) - w_sum) : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_final = w_sum;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next_state = S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand latch, digit counters, accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ra  <= w_a_mag;
                        r_rb  <= w_b_mag;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_last ? w_final : w_sum;
                    // j is the inner digit index
                    if (r_j == C_LAST) begin
                        r_j <= '0;
                        r_i <= w_last ? '0 : (r_i + C_CW'(1));
                    end else begin
                        r_j <= r_j + C_CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_acc;
    assign mx        = (r_state == S_RUN) ? r_ra[{r_i, 1'b0} +: 2] : 2'b00;
    assign my        = (r_state == S_RUN) ? r_rb[{r_j, 1'b0} +: 2] : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mulu_x2y2_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mulu_x2y2_seq
// Description : Self-checking bench for mulu_x2y2_seq. Provides the 2x2
//               multiplier behaviourally and compares handshake timing,
//               digit sequence and products against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mulu_x2y2_seq;

    localparam int WIDTH    = 8;
    localparam int C_DIGITS = WIDTH / 2;
    localparam int C_LAT    = C_DIGITS * C_DIGITS;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 sgn;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           mx;
    logic [1:0]           my;
    logic [3:0]           mp;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;

    int n_checks = 0;
    int n_errors = 0;

    // External 2x2 multiplier
    assign mp = 4'(mx) * 4'(my);

    mulu_x2y2_seq #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MULU_SEQ_SIGNED_EN
        .sgn       (sgn),
`endif
        .a         (a),
        .b         (b),
        .mx        (mx),
        .my        (my),
        .mp        (mp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand as an integer value under the selected interpretation
    function automatic longint op_val(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) return longint'(v) - (longint'(1) << WIDTH);
        return longint'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] model_product(input logic [WIDTH-1:0] x,
                                                         input logic [WIDTH-1:0] y,
                                                         input logic s);
        longint p;
        p = op_val(x, s) * op_val(y, s);
        return p[2*WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] model_mag(input logic [WIDTH-1:0] v, input logic s);
        longint m;
        m = op_val(v, s);
        if (m < 0) m = -m;
        return m[WIDTH-1:0];
    endfunction

    // One complete multiply: accept, RUN, optional result stall, release.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts, input int stall);
        logic [2*WIDTH-1:0] exp_p;
        logic [WIDTH-1:0]   ma;
        logic [WIDTH-1:0]   mb;
        int                 n;
        exp_p = model_product(ta, tb, ts);
        ma    = model_mag(ta, ts);
        mb    = model_mag(tb, ts);

        @(negedge clk);
        check("accept_in_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        sgn       = ts;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n < C_LAT) begin
                check("mx_digit", mx, 2'((ma >> (2 * (n / C_DIGITS))) & 3));
                check("my_digit", my, 2'((mb >> (2 * (n % C_DIGITS))) & 3));
            end
            if (n == 5) check("run_in_ready", in_ready, 1'b0);
            // Operand changes and a stray request during RUN must be ignored.
            in_valid = (n == 3);
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            sgn      = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'(C_LAT));
        check("result", result, exp_p);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_result", result, exp_p);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        check("idle_result_hold", result, exp_p);
        check("idle_mx", mx, 2'b00);
        check("idle_my", my, 2'b00);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sgn       = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, '0);
        check("rst_mx", mx, 2'b00);
        check("rst_my", my, 2'b00);
        rst = 1'b0;

        // Directed cases
        run_op(8'hFF, 8'hFF, 1'b0, 0);
        run_op(8'h00, 8'hA5, 1'b0, 0);
        run_op(8'h37, 8'h12, 1'b0, 5);
        run_op(8'h10, 8'h10, 1'b0, 0);

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hC3;
        b = 8'h7E;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_result", result, '0);
        check("abort_mx", mx, 2'b00);
        check("abort_my", my, 2'b00);
        repeat (C_LAT + 2) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 1'b0);
        end
        run_op(8'h03, 8'h03, 1'b0, 0);

        // Reset beats a simultaneous request
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_wins_in_ready", in_ready, 1'b1);
        check("rst_wins_result", result, '0);
        @(negedge clk);
        check("rst_wins_mx", mx, 2'b00);

`ifdef MULU_SEQ_SIGNED_EN
        run_op(8'hFD, 8'h05, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b1, 0);
        run_op(8'hFD, 8'h05, 1'b0, 0);
`endif

        // Randomized operands and back-pressure
        for (int k = 0; k < 24; k++) begin
            logic ts;
`ifdef MULU_SEQ_SIGNED_EN
            ts = 1'($urandom);
`else
            ts = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), ts, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
